result_dispatch: RTL and testbench
==================================

RESULT_DISPATCH -- requirements
Module: result_dispatch

Interface
REQ-001 Parameter DW, default 32, width of result data word.
REQ-002 Parameter CW, default 16, width of per-destination frame word counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  1  result FIFO holds no words.
REQ-006 fifo_rd_en  output  1  one-cycle pop request to result FIFO.
REQ-007 fifo_rd_data  input  DW  popped result word, valid the cycle after fifo_rd_en.
REQ-008 fifo_rd_src  input  1  destination tag of popped word (0 = mstr0, 1 = mstr1), same timing as fifo_rd_data.
REQ-009 fifo_rd_mode  input  2  processing mode of popped word, same timing.
REQ-010 fifo_rd_proc_val  input  8  processing value of popped word, same timing.
REQ-011 frame_len  input  CW  words per frame per destination; held stable during a frame.
REQ-012 mstr_valid  output  2  bit i: word presented to destination i.
REQ-013 mstr_ready  input  2  bit i: destination i accepts word.
REQ-014 mstr_data  output  2*DW  slice i = data for destination i.
REQ-015 mstr_mode  output  4  slice i (2 bits) = mode for destination i.
REQ-016 mstr_proc_val  output  16  slice i (8 bits) = proc value for destination i.
REQ-017 mstr_cmplt  output  2  bit i: one-cycle pulse, frame to destination i finished.
REQ-018 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-019 FSM states IDLE, READ, HOLD; one word in flight at most.
REQ-020 IDLE: fifo_empty=0 -> fifo_rd_en=1 this cycle, next state READ; else stay IDLE, fifo_rd_en=0.
REQ-021 READ: capture fifo_rd_data/src/mode/proc_val into slice src; mstr_valid[src]=1 from next cycle; next state HOLD.
REQ-022 HOLD: mstr_valid[src]=1 and slice outputs stable until mstr_ready[src]=1; mstr_ready of other destination ignored.
REQ-023 Handshake cycle (valid&ready): mstr_valid[src] cleared next cycle; count[src] incremented.
REQ-024 Handshake cycle with fifo_empty=0: fifo_rd_en=1 same cycle, next state READ (sustained rate 1 word / 2 cycles); with fifo_empty=1: next state IDLE.
REQ-025 fifo_rd_en never asserted while fifo_empty=1, never asserted in READ, never in HOLD without handshake.
REQ-026 At most one mstr_valid bit high at any cycle.
REQ-027 Non-selected destination slice retains its last delivered values.
REQ-028 count[i] is CW bits; when handshake makes count[i]+1 == frame_len, mstr_cmplt[i] pulses 1 cycle (registered, cycle after handshake), count[i] returns 0.
REQ-029 frame_len=0 treated as 1 (cmplt after every word to that destination).
REQ-030 Counters independent; interleaved src tags advance only their own counter.
REQ-031 mstr_cmplt for both bits never high simultaneously (follows REQ-026).

Reset
REQ-032 rst=1 forces immediately: state IDLE, fifo_rd_en=0, mstr_valid=0, mstr_cmplt=0, busy=0, count[0]=count[1]=0, mstr_data/mode/proc_val=0.
REQ-033 Reset mid-operation discards any in-flight or presented word without handshake; no cmplt generated.
REQ-034 First fifo_rd_en no earlier than first rising edge after rst deasserts.

Verification
REQ-035 Single word: FIFO holds {src=1,data=0xDEADBEEF,mode=2,proc=0x5A}, mstr_ready=2'b10 -> rd_en cycle 0, mstr_valid=2'b10 cycle 2 with those values, drops cycle 3; mstr_valid[0] never high.
REQ-036 Backpressure: mstr_ready[0]=0 for 5 cycles while word src=0 presented -> valid and data stable 5 cycles, no fifo_rd_en, accepted on ready, then next pop.
REQ-037 Frame: frame_len=4, 4 words src=0 with ready held high -> rd_en every 2 cycles, mstr_cmplt[0] single pulse one cycle after 4th handshake, count back to 0; 5th word starts new frame.
REQ-038 Interleave: frame_len=2, tags 0,1,0,1 -> cmplt[0] after 3rd word, cmplt[1] after 4th word, never together.
REQ-039 Reset: rst asserted while in HOLD with valid high -> mstr_valid=0, busy=0 asynchronously; after release, remaining FIFO words delivered with counters starting at 0.
REQ-040 Empty FIFO: fifo_empty=1 for 20 cycles -> fifo_rd_en=0, busy=0, all outputs unchanged.

Source files
------------

// File: rtl/result_dispatch.sv
// Result dispatcher: pops one word at a time from the result FIFO, presents it to the
// destination named by its tag, and pulses a per-destination frame-complete strobe.
module result_dispatch #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty,
  output logic            fifo_rd_en,
  input  logic [DW-1:0]   fifo_rd_data,
  input  logic            fifo_rd_src,
  input  logic [1:0]      fifo_rd_mode,
  input  logic [7:0]      fifo_rd_proc_val,
  input  logic [CW-1:0]   frame_len,
  output logic [1:0]      mstr_valid,
  input  logic [1:0]      mstr_ready,
  output logic [2*DW-1:0] mstr_data,
  output logic [3:0]      mstr_mode,
  output logic [15:0]     mstr_proc_val,
  output logic [1:0]      mstr_cmplt,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          cur_src;
  logic          armed;
  logic          handshake;
  logic [CW-1:0] count [2];
  logic [CW-1:0] eff_len;
  logic [CW:0]   count_inc;

  assign handshake  = (state == HOLD) && mstr_ready[cur_src];
  assign busy       = (state != IDLE);
  assign mstr_valid = (state == HOLD) ? (cur_src ? 2'b10 : 2'b01) : 2'b00;
  // A zero frame length behaves as a one-word frame.
  assign eff_len    = (frame_len == '0) ? CW'(1) : frame_len;
  assign count_inc  = {1'b0, count[cur_src]} + (CW+1)'(1);

  // armed holds off the first pop until a clock edge has passed after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      armed   <= 1'b0;
      cur_src <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      if (state == READ) begin
        cur_src <= fifo_rd_src;
      end
    end
  end

  always_comb begin
    next_state = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        next_state = HOLD;
      end
      HOLD: begin
        // Popping on the handshake cycle sustains one word every two cycles.
        if (handshake) begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            next_state = READ;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Only the addressed slice is overwritten; the other keeps its last delivered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstr_data     <= '0;
      mstr_mode     <= '0;
      mstr_proc_val <= '0;
    end else if (state == READ) begin
      if (fifo_rd_src) begin
        mstr_data[DW +: DW]  <= fifo_rd_data;
        mstr_mode[3:2]       <= fifo_rd_mode;
        mstr_proc_val[15:8]  <= fifo_rd_proc_val;
      end else begin
        mstr_data[0 +: DW]   <= fifo_rd_data;
        mstr_mode[1:0]       <= fifo_rd_mode;
        mstr_proc_val[7:0]   <= fifo_rd_proc_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count[0]   <= '0;
      count[1]   <= '0;
      mstr_cmplt <= '0;
    end else begin
      mstr_cmplt <= '0;
      if (handshake) begin
        if (count_inc >= {1'b0, eff_len}) begin
          count[cur_src]      <= '0;
          mstr_cmplt[cur_src] <= 1'b1;
        end else begin
          count[cur_src] <= count_inc[CW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_result_dispatch.sv
// Bench for result_dispatch: behavioural FIFO, scoreboard of expected deliveries and a
// per-destination frame counter model, plus directed timing checks.
module tb_result_dispatch;

  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
    logic [1:0]    mode;
    logic [7:0]    proc_val;
  } word_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            fifo_empty = 1'b1;
  logic            fifo_rd_en;
  logic [DW-1:0]   fifo_rd_data = '0;
  logic            fifo_rd_src = 1'b0;
  logic [1:0]      fifo_rd_mode = '0;
  logic [7:0]      fifo_rd_proc_val = '0;
  logic [CW-1:0]   frame_len = CW'(1);
  logic [1:0]      mstr_valid;
  logic [1:0]      mstr_ready = 2'b00;
  logic [2*DW-1:0] mstr_data;
  logic [3:0]      mstr_mode;
  logic [15:0]     mstr_proc_val;
  logic [1:0]      mstr_cmplt;
  logic            busy;

  result_dispatch #(.DW(DW), .CW(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_src      (fifo_rd_src),
    .fifo_rd_mode     (fifo_rd_mode),
    .fifo_rd_proc_val (fifo_rd_proc_val),
    .frame_len        (frame_len),
    .mstr_valid       (mstr_valid),
    .mstr_ready       (mstr_ready),
    .mstr_data        (mstr_data),
    .mstr_mode        (mstr_mode),
    .mstr_proc_val    (mstr_proc_val),
    .mstr_cmplt       (mstr_cmplt),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  word_t fifo_q[$];
  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cnt_model[2] = '{0, 0};
  int    cmplt_seen[2] = '{0, 0};
  logic [1:0] exp_cmplt = 2'b00;

  logic            snap_rd_en;
  logic            snap_busy;
  logic [1:0]      snap_valid;
  logic [1:0]      snap_cmplt;
  logic [2*DW-1:0] snap_data;
  logic [3:0]      snap_mode;
  logic [15:0]     snap_proc;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len();
    if (frame_len == '0) return 1;
    return int'(frame_len);
  endfunction

  task automatic push_word(input logic src, input logic [DW-1:0] data,
                           input logic [1:0] mode, input logic [7:0] pv);
    word_t w;
    w.src      = src;
    w.data     = data;
    w.mode     = mode;
    w.proc_val = pv;
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: check at the falling edge, then model the FIFO pop just after the rising edge.
  task automatic tick();
    logic       rd_s;
    logic [1:0] new_cmplt;
    word_t      e;
    @(negedge clk);
    snap_rd_en = fifo_rd_en;
    snap_busy  = busy;
    snap_valid = mstr_valid;
    snap_cmplt = mstr_cmplt;
    snap_data  = mstr_data;
    snap_mode  = mstr_mode;
    snap_proc  = mstr_proc_val;
    check_output("valid_onehot", 64'($countones(mstr_valid) <= 1), 64'd1);
    check_output("cmplt_not_both", 64'(mstr_cmplt == 2'b11), 64'd0);
    check_output("rd_en_when_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
    check_output("cmplt", 64'(mstr_cmplt), 64'(exp_cmplt));
    if (rst) check_output("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
    for (int i = 0; i < 2; i++) if (mstr_cmplt[i]) cmplt_seen[i]++;
    new_cmplt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (mstr_valid[i] && mstr_ready[i]) begin
        check_output("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("src", 64'(i), 64'(e.src));
          check_output("data", 64'(mstr_data[i*DW +: DW]), 64'(e.data));
          check_output("mode", 64'(mstr_mode[i*2 +: 2]), 64'(e.mode));
          check_output("proc_val", 64'(mstr_proc_val[i*8 +: 8]), 64'(e.proc_val));
          cnt_model[i]++;
          if (cnt_model[i] >= eff_len()) begin
            cnt_model[i] = 0;
            new_cmplt[i] = 1'b1;
          end
        end
      end
    end
    exp_cmplt = new_cmplt;
    rd_s = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) begin
      e = fifo_q.pop_front();
      fifo_rd_src      = e.src;
      fifo_rd_data     = e.data;
      fifo_rd_mode     = e.mode;
      fifo_rd_proc_val = e.proc_val;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
      tick();
      n++;
    end
    check_output("drain_in_budget", 64'(n < max_cycles), 64'd1);
    tick();
  endtask

  // A word already popped (READ or HOLD) is lost by reset, so it leaves the scoreboard.
  task automatic apply_stimulus_reset();
    word_t lost;
    if (busy === 1'b1 && exp_q.size() > 0) lost = exp_q.pop_front();
    rst = 1'b1;
    exp_cmplt = 2'b00;
    cnt_model[0] = 0;
    cnt_model[1] = 0;
    #1;
    check_output("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check_output("rst_valid", 64'(mstr_valid), 64'd0);
    check_output("rst_cmplt", 64'(mstr_cmplt), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_data", 64'(mstr_data), 64'd0);
    check_output("rst_mode", 64'(mstr_mode), 64'd0);
    check_output("rst_proc", 64'(mstr_proc_val), 64'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    int s1;
    logic [2*DW-1:0] keep_data;
    logic [3:0]      keep_mode;
    logic [15:0]     keep_proc;

    // Single word to destination 1, FIFO already non-empty during reset.
    #2;
    push_word(1'b1, 32'hDEADBEEF, 2'd2, 8'h5A);
    mstr_ready = 2'b10;
    frame_len  = CW'(1);
    apply_stimulus_reset();
    tick();
    check_output("no_rd_en_before_edge", 64'(snap_rd_en), 64'd0);
    tick();
    check_output("single_c0_rd_en", 64'(snap_rd_en), 64'd1);
    check_output("single_c0_valid", 64'(snap_valid), 64'd0);
    tick();
    check_output("single_c1_rd_en", 64'(snap_rd_en), 64'd0);
    check_output("single_c1_valid", 64'(snap_valid), 64'd0);
    check_output("single_c1_busy", 64'(snap_busy), 64'd1);
    tick();
    check_output("single_c2_valid", 64'(snap_valid), 64'h2);
    check_output("single_c2_data", 64'(snap_data[DW +: DW]), 64'hDEADBEEF);
    check_output("single_c2_mode", 64'(snap_mode[3:2]), 64'd2);
    check_output("single_c2_proc", 64'(snap_proc[15:8]), 64'h5A);
    tick();
    check_output("single_c3_valid", 64'(snap_valid), 64'd0);
    check_output("single_c3_cmplt", 64'(snap_cmplt), 64'h2);
    tick();

    // Backpressure on destination 0 while destination 1 signals ready.
    frame_len  = CW'(2);
    mstr_ready = 2'b10;
    push_word(1'b0, 32'h11110000, 2'd1, 8'h01);
    push_word(1'b0, 32'h22220000, 2'd3, 8'h02);
    tick();
    check_output("bp_rd_en", 64'(snap_rd_en), 64'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output("bp_hold_valid", 64'(snap_valid), 64'h1);
      check_output("bp_hold_rd_en", 64'(snap_rd_en), 64'd0);
      check_output("bp_hold_data", 64'(snap_data[0 +: DW]), 64'h11110000);
    end
    mstr_ready = 2'b01;
    tick();
    check_output("bp_accept_rd_en", 64'(snap_rd_en), 64'd1);
    tick();
    check_output("bp_read_valid", 64'(snap_valid), 64'd0);
    tick();
    check_output("bp_second_data", 64'(snap_data[0 +: DW]), 64'h22220000);
    check_output("bp_keep_slice1", 64'(snap_data[DW +: DW]), 64'hDEADBEEF);
    tick();
    check_output("bp_frame_cmplt", 64'(snap_cmplt), 64'h1);
    drain(20);

    // Four-word frame at full rate, then a fifth word opening a new frame.
    frame_len  = CW'(4);
    mstr_ready = 2'b11;
    for (int k = 0; k < 5; k++) push_word(1'b0, 32'h30000000 + 32'(k), 2'(k), 8'(k));
    s0 = cmplt_seen[0];
    for (int k = 0; k < 12; k++) begin
      tick();
      check_output("frame_rd_en_rate", 64'(snap_rd_en), 64'((k % 2 == 0) && (k <= 8)));
      check_output("frame_cmplt_time", 64'(snap_cmplt), (k == 9) ? 64'h1 : 64'h0);
    end
    for (int k = 0; k < 3; k++) push_word(1'b0, 32'h31000000 + 32'(k), 2'd1, 8'hF0);
    drain(30);
    check_output("frame_cmplt_count", 64'(cmplt_seen[0] - s0), 64'd2);

    // Interleaved tags with two-word frames.
    frame_len = CW'(2);
    push_word(1'b0, 32'h40000000, 2'd0, 8'h10);
    push_word(1'b1, 32'h40000001, 2'd1, 8'h11);
    push_word(1'b0, 32'h40000002, 2'd2, 8'h12);
    push_word(1'b1, 32'h40000003, 2'd3, 8'h13);
    s0 = cmplt_seen[0];
    s1 = cmplt_seen[1];
    drain(30);
    check_output("ilv_cmplt0", 64'(cmplt_seen[0] - s0), 64'd1);
    check_output("ilv_cmplt1", 64'(cmplt_seen[1] - s1), 64'd1);

    // Reset while a word is presented; the counter must restart from zero.
    frame_len  = CW'(3);
    mstr_ready = 2'b10;
    push_word(1'b1, 32'h50000000, 2'd0, 8'h20);
    drain(20);
    mstr_ready = 2'b00;
    for (int k = 1; k <= 4; k++) push_word(1'b1, 32'h50000000 + 32'(k), 2'(k), 8'h20 + 8'(k));
    tick();
    tick();
    tick();
    tick();
    check_output("rst_mid_valid_before", 64'(mstr_valid), 64'h2);
    check_output("rst_mid_busy_before", 64'(busy), 64'd1);
    s1 = cmplt_seen[1];
    mstr_ready = 2'b10;
    apply_stimulus_reset();
    tick();
    check_output("rst_mid_no_early_rd", 64'(snap_rd_en), 64'd0);
    drain(30);
    check_output("rst_mid_cmplt_count", 64'(cmplt_seen[1] - s1), 64'd1);

    // Zero frame length completes after every word.
    frame_len  = CW'(0);
    mstr_ready = 2'b11;
    push_word(1'b1, 32'h60000000, 2'd1, 8'h30);
    push_word(1'b0, 32'h60000001, 2'd2, 8'h31);
    push_word(1'b1, 32'h60000002, 2'd3, 8'h32);
    s0 = cmplt_seen[0];
    s1 = cmplt_seen[1];
    drain(30);
    check_output("zero_len_cmplt0", 64'(cmplt_seen[0] - s0), 64'd1);
    check_output("zero_len_cmplt1", 64'(cmplt_seen[1] - s1), 64'd2);

    // Idle with an empty FIFO: nothing moves.
    keep_data = mstr_data;
    keep_mode = mstr_mode;
    keep_proc = mstr_proc_val;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_output("idle_rd_en", 64'(snap_rd_en), 64'd0);
      check_output("idle_busy", 64'(snap_busy), 64'd0);
      check_output("idle_valid", 64'(snap_valid), 64'd0);
      check_output("idle_data", 64'(snap_data[DW +: DW]), 64'(keep_data[DW +: DW]));
      check_output("idle_mode", 64'(snap_mode), 64'(keep_mode));
      check_output("idle_proc", 64'(snap_proc), 64'(keep_proc));
    end
    check_output("idle_final_data", 64'(mstr_data[DW +: DW]), 64'h60000002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
